// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multicycle issue/control stage that drives the RV32I ALU. It accepts one
//   decoded instruction bundle and sequences one ALU cycle (ALU-type ops and
//   jumps) or two ALU cycles (branches: compare, then target). It then
//   presents the writeback value, next PC and branch decision.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready bundle handshake (opcode, funct3, funct7_5, rs1_val,
//                     rs2_val, imm, pc)
//   alu_operation/lhs/rhs   drive to the ALU
//   alu_result/zero         combinational return from the ALU
//   out_valid/out_ready     result handshake (rd_value, rd_write, next_pc,
//                           branch_taken, illegal)
module alu_sequencer #(
  parameter int XLEN = 32,
  parameter int OLEN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [OLEN-1:0] alu_operation,
  output logic [XLEN-1:0] alu_lhs,
  output logic [XLEN-1:0] alu_rhs,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_value,
  output logic            rd_write,
  output logic [XLEN-1:0] next_pc,
  output logic            branch_taken,
  output logic            illegal
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_TARGET = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [OLEN-1:0] ALU_ADD  = OLEN'(0);
  localparam logic [OLEN-1:0] ALU_SUB  = OLEN'(1);
  localparam logic [OLEN-1:0] ALU_SLT  = OLEN'(2);
  localparam logic [OLEN-1:0] ALU_SLTU = OLEN'(3);
  localparam logic [OLEN-1:0] ALU_AND  = OLEN'(4);
  localparam logic [OLEN-1:0] ALU_OR   = OLEN'(5);
  localparam logic [OLEN-1:0] ALU_XOR  = OLEN'(6);
  localparam logic [OLEN-1:0] ALU_SL   = OLEN'(7);
  localparam logic [OLEN-1:0] ALU_SRL  = OLEN'(8);
  localparam logic [OLEN-1:0] ALU_SRA  = OLEN'(9);

  logic [1:0]      state_reg;
  logic [6:0]      opcode_reg;
  logic [2:0]      funct3_reg;
  logic            funct7_5_reg;
  logic [XLEN-1:0] rs1_reg;
  logic [XLEN-1:0] rs2_reg;
  logic [XLEN-1:0] imm_reg;
  logic [XLEN-1:0] pc_reg;

  logic [XLEN-1:0] rd_value_reg;
  logic            rd_write_reg;
  logic [XLEN-1:0] next_pc_reg;
  logic            branch_taken_reg;
  logic            illegal_reg;

  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] rhs_sel;
  logic            opcode_ok;
  logic            branch_f3_ok;
  logic            taken_next;

  assign pc4 = pc_reg + XLEN'(4);

  assign in_ready     = (state_reg == S_IDLE);
  assign out_valid    = (state_reg == S_DONE);
  assign rd_value     = rd_value_reg;
  assign rd_write     = rd_write_reg;
  assign next_pc      = next_pc_reg;
  assign branch_taken = branch_taken_reg;
  assign illegal      = illegal_reg;

  // Decided on the incoming opcode so unsupported bundles skip EXEC entirely.
  always_comb begin
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR, OPC_BRANCH: opcode_ok = 1'b1;
      default:                       opcode_ok = 1'b0;
    endcase
  end

  // funct3 010/011 are not branch encodings.
  assign branch_f3_ok = (funct3_reg[2:1] != 2'b01);

  // beq/bge/bgeu are taken on a zero compare result, bne/blt/bltu on nonzero.
  // funct3[0] and funct3[2] together flip the sense of alu_zero.
  assign taken_next = alu_zero ^ funct3_reg[0] ^ funct3_reg[2];

  // ALU drive; IDLE and DONE leave it at add 0,0.
  always_comb begin
    alu_operation = ALU_ADD;
    alu_lhs       = '0;
    alu_rhs       = '0;
    rhs_sel       = (opcode_reg == OPC_OP) ? rs2_reg : imm_reg;
    if (state_reg == S_EXEC) begin
      case (opcode_reg)
        OPC_OP, OPC_OP_IMM: begin
          alu_lhs = rs1_reg;
          alu_rhs = rhs_sel;
          case (funct3_reg)
            3'b000: alu_operation = (opcode_reg == OPC_OP && funct7_5_reg) ? ALU_SUB : ALU_ADD;
            3'b001: begin
              alu_operation = ALU_SL;
              alu_rhs       = {{(XLEN-5){1'b0}}, rhs_sel[4:0]};
            end
            3'b010: alu_operation = ALU_SLT;
            3'b011: alu_operation = ALU_SLTU;
            3'b100: alu_operation = ALU_XOR;
            3'b101: begin
              alu_operation = funct7_5_reg ? ALU_SRA : ALU_SRL;
              alu_rhs       = {{(XLEN-5){1'b0}}, rhs_sel[4:0]};
            end
            3'b110: alu_operation = ALU_OR;
            3'b111: alu_operation = ALU_AND;
          endcase
        end
        OPC_LUI: alu_rhs = imm_reg;
        OPC_AUIPC, OPC_JAL: begin
          alu_lhs = pc_reg;
          alu_rhs = imm_reg;
        end
        OPC_JALR: begin
          alu_lhs = rs1_reg;
          alu_rhs = imm_reg;
        end
        OPC_BRANCH: begin
          alu_lhs = rs1_reg;
          alu_rhs = rs2_reg;
          case (funct3_reg[2:1])
            2'b10:   alu_operation = ALU_SLT;
            2'b11:   alu_operation = ALU_SLTU;
            default: alu_operation = ALU_SUB;
          endcase
        end
        default: ;
      endcase
    end else if (state_reg == S_TARGET) begin
      alu_lhs = pc_reg;
      alu_rhs = imm_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      opcode_reg       <= '0;
      funct3_reg       <= '0;
      funct7_5_reg     <= 1'b0;
      rs1_reg          <= '0;
      rs2_reg          <= '0;
      imm_reg          <= '0;
      pc_reg           <= '0;
      rd_value_reg     <= '0;
      rd_write_reg     <= 1'b0;
      next_pc_reg      <= '0;
      branch_taken_reg <= 1'b0;
      illegal_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            opcode_reg       <= opcode;
            funct3_reg       <= funct3;
            funct7_5_reg     <= funct7_5;
            rs1_reg          <= rs1_val;
            rs2_reg          <= rs2_val;
            imm_reg          <= imm;
            pc_reg           <= pc;
            rd_value_reg     <= '0;
            rd_write_reg     <= 1'b0;
            branch_taken_reg <= 1'b0;
            if (opcode_ok) begin
              illegal_reg <= 1'b0;
              next_pc_reg <= '0;
              state_reg   <= S_EXEC;
            end else begin
              // pc_reg is not loaded yet, so increment the incoming pc.
              illegal_reg <= 1'b1;
              next_pc_reg <= pc + XLEN'(4);
              state_reg   <= S_DONE;
            end
          end
        end
        S_EXEC: begin
          case (opcode_reg)
            OPC_JAL, OPC_JALR: begin
              rd_value_reg <= pc4;
              rd_write_reg <= 1'b1;
              next_pc_reg  <= (opcode_reg == OPC_JALR) ?
                              {alu_result[XLEN-1:1], 1'b0} : alu_result;
              state_reg    <= S_DONE;
            end
            OPC_BRANCH: begin
              if (branch_f3_ok) begin
                branch_taken_reg <= taken_next;
                state_reg        <= S_TARGET;
              end else begin
                illegal_reg <= 1'b1;
                next_pc_reg <= pc4;
                state_reg   <= S_DONE;
              end
            end
            default: begin
              // OP, OP-IMM, LUI, AUIPC
              rd_value_reg <= alu_result;
              rd_write_reg <= 1'b1;
              next_pc_reg  <= pc4;
              state_reg    <= S_DONE;
            end
          endcase
        end
        S_TARGET: begin
          next_pc_reg  <= branch_taken_reg ? alu_result : pc4;
          rd_value_reg <= '0;
          rd_write_reg <= 1'b0;
          state_reg    <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            state_reg <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural RV32I ALU closing the
// alu_* loop. Expected values are hand-computed constants.
module tb_alu_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [31:0] pc;
  logic [3:0]  alu_operation;
  logic [31:0] alu_lhs;
  logic [31:0] alu_rhs;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rd_value;
  logic        rd_write;
  logic [31:0] next_pc;
  logic        branch_taken;
  logic        illegal;

  int check_count = 0;
  int pass_count  = 0;
  logic [31:0] op_seen;
  logic [31:0] rhs_seen;

  alu_sequencer #(.XLEN(32), .OLEN(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
    .alu_operation(alu_operation), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_value(rd_value), .rd_write(rd_write), .next_pc(next_pc),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment ALU
  always_comb begin
    case (alu_operation)
      4'd0:    alu_result = alu_lhs + alu_rhs;
      4'd1:    alu_result = alu_lhs - alu_rhs;
      4'd2:    alu_result = {31'd0, $signed(alu_lhs) < $signed(alu_rhs)};
      4'd3:    alu_result = {31'd0, alu_lhs < alu_rhs};
      4'd4:    alu_result = alu_lhs & alu_rhs;
      4'd5:    alu_result = alu_lhs | alu_rhs;
      4'd6:    alu_result = alu_lhs ^ alu_rhs;
      4'd7:    alu_result = alu_lhs << alu_rhs[4:0];
      4'd8:    alu_result = alu_lhs >> alu_rhs[4:0];
      4'd9:    alu_result = $unsigned($signed(alu_lhs) >>> alu_rhs[4:0]);
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
  endtask

  // Present a bundle, wait for acceptance, then scramble the inputs so any
  // failure to latch shows up. Samples the ALU drive of the first cycle.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] p);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    check_eq("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    opcode = op; funct3 = f3; funct7_5 = f75;
    rs1_val = a; rs2_val = b; imm = im; pc = p;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode = 7'h7f; funct3 = 3'h7; funct7_5 = 1'b1;
    rs1_val = 32'hdeadbeef; rs2_val = 32'hcafef00d; imm = 32'h5a5a5a5a; pc = 32'h13579bdf;
    op_seen  = {28'd0, alu_operation};
    rhs_seen = alu_rhs;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("retire_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("retire_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic expect_result(input string tag, input int exp_lat,
                               input logic [31:0] exp_rd, input logic exp_wr,
                               input logic [31:0] exp_npc, input logic exp_bt,
                               input logic exp_ill);
    int lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_rd_value"}, rd_value, exp_rd);
    check_eq({tag, "_rd_write"}, {31'd0, rd_write}, {31'd0, exp_wr});
    check_eq({tag, "_next_pc"}, next_pc, exp_npc);
    check_eq({tag, "_branch_taken"}, {31'd0, branch_taken}, {31'd0, exp_bt});
    check_eq({tag, "_illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
    $display("txn %s: rd=0x%08h wr=%0d npc=0x%08h bt=%0d ill=%0d lat=%0d",
             tag, rd_value, rd_write, next_pc, branch_taken, illegal, lat);
    retire();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; funct3 = '0; funct7_5 = 1'b0;
    rs1_val = '0; rs2_val = '0; imm = '0; pc = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_rd_value", rd_value, 32'd0);
    check_eq("rst_next_pc", next_pc, 32'd0);
    check_eq("rst_illegal", {31'd0, illegal}, 32'd0);
    check_eq("rst_alu_lhs", alu_lhs, 32'd0);
    check_eq("rst_alu_op", {28'd0, alu_operation}, 32'd0);

    // OP add 5+7
    issue(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 32'h200);
    check_eq("add_alu_op", op_seen, 32'd0);
    expect_result("add", 1, 32'd12, 1'b1, 32'h204, 1'b0, 1'b0);

    // OP sub 5-7
    issue(7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 32'h200);
    check_eq("sub_alu_op", op_seen, 32'd1);
    expect_result("sub", 1, 32'hfffffffe, 1'b1, 32'h204, 1'b0, 1'b0);

    // OP-IMM srai by 4 (imm=0x404 -> shamt 4)
    issue(7'b0010011, 3'b101, 1'b1, 32'h80000000, 32'd0, 32'h404, 32'h210);
    check_eq("srai_alu_op", op_seen, 32'd9);
    check_eq("srai_alu_rhs", rhs_seen, 32'd4);
    expect_result("srai", 1, 32'hf8000000, 1'b1, 32'h214, 1'b0, 1'b0);

    // OP-IMM addi with bit 30 set must still add
    issue(7'b0010011, 3'b000, 1'b1, 32'h10, 32'd0, 32'h400, 32'h220);
    check_eq("addi_alu_op", op_seen, 32'd0);
    expect_result("addi", 1, 32'h410, 1'b1, 32'h224, 1'b0, 1'b0);

    // OP sll 1 << 31 (rs2 upper bits ignored)
    issue(7'b0110011, 3'b001, 1'b0, 32'd1, 32'hffffffff, 32'd0, 32'h230);
    check_eq("sll_alu_rhs", rhs_seen, 32'd31);
    expect_result("sll", 1, 32'h80000000, 1'b1, 32'h234, 1'b0, 1'b0);

    // LUI and AUIPC
    issue(7'b0110111, 3'b000, 1'b0, 32'h55, 32'd0, 32'h12345000, 32'h240);
    expect_result("lui", 1, 32'h12345000, 1'b1, 32'h244, 1'b0, 1'b0);
    issue(7'b0010111, 3'b000, 1'b0, 32'h55, 32'd0, 32'h2000, 32'h1000);
    expect_result("auipc", 1, 32'h3000, 1'b1, 32'h1004, 1'b0, 1'b0);

    // Branches
    issue(7'b1100011, 3'b000, 1'b0, 32'd3, 32'd3, 32'h20, 32'h100);
    check_eq("beq_alu_op", op_seen, 32'd1);
    expect_result("beq_taken", 2, 32'd0, 1'b0, 32'h120, 1'b1, 1'b0);
    issue(7'b1100011, 3'b001, 1'b0, 32'd3, 32'd3, 32'h20, 32'h100);
    expect_result("bne_not_taken", 2, 32'd0, 1'b0, 32'h104, 1'b0, 1'b0);
    issue(7'b1100011, 3'b100, 1'b0, 32'hffffffff, 32'd1, 32'hfffffff0, 32'h300);
    check_eq("blt_alu_op", op_seen, 32'd2);
    expect_result("blt_taken", 2, 32'd0, 1'b0, 32'h2f0, 1'b1, 1'b0);
    issue(7'b1100011, 3'b111, 1'b0, 32'hffffffff, 32'd1, 32'h8, 32'h300);
    check_eq("bgeu_alu_op", op_seen, 32'd3);
    expect_result("bgeu_taken", 2, 32'd0, 1'b0, 32'h308, 1'b1, 1'b0);
    issue(7'b1100011, 3'b110, 1'b0, 32'hffffffff, 32'd1, 32'h8, 32'h300);
    expect_result("bltu_not_taken", 2, 32'd0, 1'b0, 32'h304, 1'b0, 1'b0);

    // Jumps
    issue(7'b1100111, 3'b000, 1'b0, 32'h1001, 32'd0, 32'd2, 32'h40);
    expect_result("jalr", 1, 32'h44, 1'b1, 32'h1002, 1'b0, 1'b0);
    issue(7'b1101111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h10, 32'hfffffffc);
    expect_result("jal_wrap", 1, 32'd0, 1'b1, 32'h0000000c, 1'b0, 1'b0);

    // Illegal opcode and illegal branch funct3
    issue(7'b0000011, 3'b010, 1'b0, 32'd1, 32'd2, 32'd3, 32'h500);
    expect_result("illegal_load", 0, 32'd0, 1'b0, 32'h504, 1'b0, 1'b1);
    issue(7'b1100011, 3'b010, 1'b0, 32'd1, 32'd2, 32'h40, 32'h500);
    expect_result("illegal_branch", 1, 32'd0, 1'b0, 32'h504, 1'b0, 1'b1);

    // Backpressure: hold 5 cycles with a competing bundle offered
    issue(7'b0110011, 3'b110, 1'b0, 32'hf0, 32'h0f, 32'd0, 32'h600);
    begin
      int lat = 0;
      while (!out_valid && lat < 10) begin
        @(posedge clk); #1; lat++;
      end
    end
    opcode = 7'b0110011; funct3 = 3'b000; rs1_val = 32'd9; rs2_val = 32'd9; pc = 32'h700;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_rd_value", rd_value, 32'hff);
      check_eq("bp_next_pc", next_pc, 32'h604);
      $display("txn bp_hold cycle %0d: out_valid=%0d rd=0x%08h", i, out_valid, rd_value);
    end
    in_valid = 1'b0;
    retire();

    // Reset while in TARGET
    issue(7'b1100011, 3'b000, 1'b0, 32'd3, 32'd3, 32'h20, 32'h100);
    @(posedge clk); #1;
    check_eq("tgt_out_valid_before_rst", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_rd_value", rd_value, 32'd0);
    check_eq("mid_rst_next_pc", next_pc, 32'd0);
    check_eq("mid_rst_branch_taken", {31'd0, branch_taken}, 32'd0);
    check_eq("mid_rst_rd_write", {31'd0, rd_write}, 32'd0);
    check_eq("mid_rst_alu_lhs", alu_lhs, 32'd0);
    $display("txn mid_reset: in_ready=%0d out_valid=%0d npc=0x%08h", in_ready, out_valid, next_pc);
    repeat (3) @(posedge clk);
    #1 check_eq("mid_rst_discarded", {31'd0, out_valid}, 32'd0);

    // Normal operation after the mid-sequence reset
    issue(7'b0110011, 3'b100, 1'b0, 32'hff00ff00, 32'h0ff00ff0, 32'd0, 32'h800);
    check_eq("xor_alu_op", op_seen, 32'd6);
    expect_result("xor", 1, 32'hf0f0f0f0, 1'b1, 32'h804, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
